fixed_shrink_stream: RTL and testbench

Streaming, pipelined fixed-point shrink activation, hard or soft, selected by parameter. It processes one beat of PARALLELISM_DIM_0*PARALLELISM_DIM_1 lanes per cycle under full valid/ready backpressure. The threshold is runtime-programmable and updates only on tensor boundaries. Output is rescaled and saturated to the output fixed-point format. It sits in the activation layer library between matmul/norm stages.

---
 rtl/fixed_shrink_stream.sv | 177 +++++++++++++++++
 tb/tb_fixed_shrink_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_shrink_stream.sv
// Streaming fixed-point shrink activation (hard or soft by MODE).
// Two registered stages: threshold compare, then rescale and saturate.
// The threshold only changes at tensor boundaries and travels with the beat.
module fixed_shrink_stream #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int MODE                        = 0,
  parameter int LAMBDA_DEFAULT_FX           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] lambda_in,
  input  logic lambda_in_valid,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready,
  output logic data_out_0_last
);

  localparam int IN_W  = DATA_IN_0_PRECISION_0;
  localparam int IN_F  = DATA_IN_0_PRECISION_1;
  localparam int OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int OUT_F = DATA_OUT_0_PRECISION_1;
  localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int TOTAL = DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1;
  localparam int BEATS = TOTAL / N;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int S1_W  = IN_W + 2;
  localparam int SH_L  = (OUT_F >= IN_F) ? OUT_F - IN_F : 0;
  localparam int SH_R  = (OUT_F >= IN_F) ? 0 : IN_F - OUT_F;
  localparam int W2    = S1_W + SH_L;
  localparam int CW    = ((W2 > OUT_W) ? W2 : OUT_W) + 1;

  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if ((TOTAL % N) != 0) begin : g_bad_parallelism
    $error("fixed_shrink_stream: tensor size must be a multiple of lanes per beat");
  end

  logic [CNT_W-1:0]      in_cnt;
  logic                  in_last;
  logic                  in_hs;
  logic                  first_beat;
  logic [IN_W-1:0]       lam_act;
  logic [IN_W-1:0]       lam_pend;
  logic                  pend_flag;
  logic [IN_W-1:0]       lam_use;
  logic signed [S1_W-1:0] lam_x;
  logic signed [S1_W-1:0] lam_neg;
  logic signed [S1_W-1:0] x;
  logic signed [S1_W-1:0] y;
  logic [N*S1_W-1:0]     s1_next;
  logic [N*S1_W-1:0]     s1_data;
  logic                  s1_valid;
  logic                  s1_last;
  logic signed [CW-1:0]  v;
  logic [N*OUT_W-1:0]    fmt_next;
  logic                  rdy1;
  logic                  rdy2;

  assign rdy2            = !data_out_0_valid || data_out_0_ready;
  assign rdy1            = !s1_valid || rdy2;
  assign data_in_0_ready = rdy1;

  assign in_hs      = data_in_0_valid && rdy1;
  assign in_last    = (in_cnt == CNT_W'(BEATS - 1));
  assign first_beat = in_hs && (in_cnt == '0);
  // A pending threshold takes effect on the first beat of the next tensor.
  assign lam_use    = ((in_cnt == '0) && pend_flag) ? lam_pend : lam_act;
  assign lam_x      = {2'b00, lam_use};
  assign lam_neg    = -lam_x;

  // Beat counter within the tensor; wraps after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt <= '0;
    end else if (in_hs) begin
      in_cnt <= in_last ? '0 : in_cnt + 1'b1;
    end
  end

  // Threshold staging: a write always lands in the pending slot, even when it
  // coincides with the tensor-start beat that consumes the previous one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lam_act   <= IN_W'(LAMBDA_DEFAULT_FX);
      lam_pend  <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (first_beat && pend_flag) begin
        lam_act <= lam_pend;
      end
      if (lambda_in_valid) begin
        lam_pend  <= lambda_in;
        pend_flag <= 1'b1;
      end else if (first_beat) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // Per-lane shrink; |x| == lambda falls into the zero band.
  always_comb begin
    s1_next = '0;
    x       = '0;
    y       = '0;
    for (int i = 0; i < N; i++) begin
      x = S1_W'($signed(data_in_0[i*IN_W +: IN_W]));
      if (x > lam_x) begin
        y = (MODE == 1) ? x - lam_x : x;
      end else if (x < lam_neg) begin
        y = (MODE == 1) ? x + lam_x : x;
      end else begin
        y = '0;
      end
      s1_next[i*S1_W +: S1_W] = y;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
    end else if (rdy1) begin
      s1_valid <= data_in_0_valid;
      if (data_in_0_valid) begin
        s1_data <= s1_next;
        s1_last <= in_last;
      end
    end
  end

  // Rescale to the output fraction (floor on right shift), then saturate.
  always_comb begin
    fmt_next = '0;
    v        = '0;
    for (int i = 0; i < N; i++) begin
      v = CW'($signed(s1_data[i*S1_W +: S1_W]));
      v = v <<< SH_L;
      v = v >>> SH_R;
      if (v > SAT_MAX) begin
        v = SAT_MAX;
      end else if (v < SAT_MIN) begin
        v = SAT_MIN;
      end
      fmt_next[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
  end

  // Stage 2 register drives the output; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_0_valid <= 1'b0;
      data_out_0       <= '0;
      data_out_0_last  <= 1'b0;
    end else if (rdy2) begin
      data_out_0_valid <= s1_valid;
      if (s1_valid) begin
        data_out_0      <= fmt_next;
        data_out_0_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_fixed_shrink_stream.sv
// Bench for fixed_shrink_stream: three instances (hardshrink, softshrink,
// softshrink into a narrow saturating format) share one stimulus stream and
// are checked against a reference model through a scoreboard queue.
module tb_fixed_shrink_stream;

  localparam int BEATS = 10;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] lambda_in;
  logic lambda_in_valid;
  logic [7:0] din;
  logic din_valid;
  logic dout_ready;
  logic rdy_h, rdy_s, rdy_q;
  logic [7:0] dout_h, dout_s;
  logic [3:0] dout_q;
  logic v_h, v_s, v_q;
  logic l_h, l_s, l_q;

  always #5 clk = ~clk;

  fixed_shrink_stream #(.MODE(0)) u_hard (
    .clk(clk), .rst(rst), .lambda_in(lambda_in), .lambda_in_valid(lambda_in_valid),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(rdy_h),
    .data_out_0(dout_h), .data_out_0_valid(v_h), .data_out_0_ready(dout_ready),
    .data_out_0_last(l_h));

  fixed_shrink_stream #(.MODE(1)) u_soft (
    .clk(clk), .rst(rst), .lambda_in(lambda_in), .lambda_in_valid(lambda_in_valid),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(rdy_s),
    .data_out_0(dout_s), .data_out_0_valid(v_s), .data_out_0_ready(dout_ready),
    .data_out_0_last(l_s));

  fixed_shrink_stream #(.MODE(1), .DATA_OUT_0_PRECISION_0(4), .DATA_OUT_0_PRECISION_1(2),
                        .LAMBDA_DEFAULT_FX(0)) u_sat (
    .clk(clk), .rst(rst), .lambda_in(lambda_in), .lambda_in_valid(lambda_in_valid),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(rdy_q),
    .data_out_0(dout_q), .data_out_0_valid(v_q), .data_out_0_ready(dout_ready),
    .data_out_0_last(l_q));

  typedef struct {
    int eh;
    int es;
    int eq;
    bit last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   cyc     = 0;
  bit   lat_mode = 0;

  // Reference model state: threshold in force for the current tensor per instance.
  int lam_cur[3];
  int lam_pend;
  bit pflag;
  int beat_no;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Shrink, then rescale from 4 fractional bits to of bits with floor, then clamp.
  function automatic int model(int x, int lam, int mode, int ow, int of);
    int y, hi, lo;
    if (x > lam)       y = (mode == 1) ? x - lam : x;
    else if (x < -lam) y = (mode == 1) ? x + lam : x;
    else               y = 0;
    if (of >= 4) y = y * (1 << (of - 4));
    else         y = y >>> (4 - of);
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: samples on the falling edge, i.e. the state that the
  // next rising edge will act on.
  initial begin : monitor
    exp_t e;
    exp_t ne;
    bit   stall_prev;
    int   hd, hl, x;
    stall_prev = 0;
    hd = 0;
    hl = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        lam_cur    = '{8, 8, 0};
        lam_pend   = 0;
        pflag      = 0;
        beat_no    = 0;
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", int'(v_h), 1);
          check("hold_data", int'(dout_h), hd);
          check("hold_last", int'(l_h), hl);
        end
        if (v_h && dout_ready) begin
          if (q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = q.pop_front();
            check("hard_data", int'($signed(dout_h)), e.eh);
            check("soft_data", int'($signed(dout_s)), e.es);
            check("sat_data", int'($signed(dout_q)), e.eq);
            check("last", int'(l_h), int'(e.last));
            check("valid_align", int'({v_s, v_q}), 3);
            if (lat_mode) check("latency", cyc - e.cyc, 2);
          end
        end
        stall_prev = v_h && !dout_ready;
        hd = int'(dout_h);
        hl = int'(l_h);
        if (din_valid && rdy_h) begin
          if ((beat_no % BEATS) == 0 && pflag) begin
            lam_cur = '{lam_pend, lam_pend, lam_pend};
            pflag   = 0;
          end
          x       = int'($signed(din));
          ne.eh   = model(x, lam_cur[0], 0, 8, 4);
          ne.es   = model(x, lam_cur[1], 1, 8, 4);
          ne.eq   = model(x, lam_cur[2], 1, 4, 2);
          ne.last = ((beat_no % BEATS) == BEATS - 1);
          ne.cyc  = cyc;
          q.push_back(ne);
          beat_no++;
          n_acc++;
        end
        if (lambda_in_valid) begin
          lam_pend = int'(lambda_in);
          pflag    = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int dir0[20] = '{9, 8, -8, -9, 0, 127, 20, -128, 6, -6,
                   -20, 5, 12, 17, -17, 16, -16, 100, -100, -1};
  int dir1[10] = '{12, 9, -9, 8, 20, -20, 127, -128, 6, 1};

  initial begin : driver
    int base, guard;
    rst = 1'b0;
    din = '0;
    din_valid = 1'b0;
    lambda_in = '0;
    lambda_in_valid = 1'b0;
    dout_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("reset_valid", int'(v_h), 0);
    check("reset_data", int'(dout_h), 0);
    check("reset_last", int'(l_h), 0);
    check("reset_ready", int'(rdy_h), 1);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Two directed tensors, no backpressure; new threshold written on beat 5.
    lat_mode = 1;
    for (int i = 0; i < 20; i++) begin
      din = 8'(dir0[i]);
      din_valid = 1'b1;
      lambda_in = 8'd16;
      lambda_in_valid = (i == 5);
      tick();
    end
    din_valid = 1'b0;
    lambda_in_valid = 1'b0;
    repeat (4) tick();
    lat_mode = 0;
    check("directed_drained", q.size(), 0);

    // Output stalled: exactly two beats fit before input ready drops.
    dout_ready = 1'b0;
    din_valid = 1'b1;
    base = n_acc;
    repeat (8) begin
      din = 8'($urandom);
      tick();
    end
    check("stall_accepted", n_acc - base, 2);
    check("stall_ready", int'(rdy_h), 0);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (4) tick();

    // Reset with a pending threshold and two beats in flight.
    lambda_in = 8'd40;
    lambda_in_valid = 1'b1;
    tick();
    lambda_in_valid = 1'b0;
    dout_ready = 1'b0;
    din_valid = 1'b1;
    din = 8'd12;
    tick();
    din = 8'hec;
    tick();
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(v_h), 0);
    check("midrst_ready", int'(rdy_h), 1);
    tick();
    rst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 8'(dir1[i]);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    repeat (4) tick();
    check("post_reset_drained", q.size(), 0);

    // Random traffic with backpressure and occasional threshold writes.
    base = n_acc;
    guard = 0;
    while ((n_acc - base) < 1000 && guard < 20000) begin
      din_valid = ($urandom_range(0, 9) < 7);
      din = 8'($urandom);
      dout_ready = ($urandom_range(0, 9) >= 3);
      lambda_in_valid = ($urandom_range(0, 19) == 0);
      lambda_in = 8'($urandom_range(0, 40));
      tick();
      guard++;
    end
    if (guard >= 20000) check("random_budget", guard, 0);
    din_valid = 1'b0;
    lambda_in_valid = 1'b0;
    dout_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    check("final_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
